// File: rtl/ctrl_mc.sv
// ctrl_mc: multi-cycle RV32I control unit with a data-memory handshake, memory timeout,
// post-jump flush, external stall and illegal-opcode trapping.
// Ports:
//   clk, rst (async, active-low);
//   opcode/func3/b from the instruction register and the comparator;
//   stall, mem_ack.
//   Outputs: imm_type, alu1_sel, alu2_sel, rd_sel and pc_sel datapath selects;
//   reg_wr, we, mem_req;
//   nop, busy, illegal and err_timeout status.
module ctrl_mc #(
    parameter int MEM_TIMEOUT  = 15,
    parameter int FLUSH_CYCLES = 1,
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    input  logic       b,
    input  logic       stall,
    input  logic       mem_ack,
    output logic [2:0] imm_type,
    output logic       alu1_sel,
    output logic       alu2_sel,
    output logic [1:0] rd_sel,
    output logic [1:0] pc_sel,
    output logic       reg_wr,
    output logic       we,
    output logic       mem_req,
    output logic       nop,
    output logic       busy,
    output logic       illegal,
    output logic       err_timeout
);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;
    localparam logic       ALU1_RS1 = 1'b0;
    localparam logic       ALU1_PC  = 1'b1;
    localparam logic       ALU2_RS2 = 1'b0;
    localparam logic       ALU2_IMM = 1'b1;
    localparam logic [1:0] RD_ALU = 2'd0;
    localparam logic [1:0] RD_MEM = 2'd1;
    localparam logic [1:0] RD_PC4 = 2'd2;
    localparam logic [1:0] RD_IMM = 2'd3;
    localparam logic [1:0] PC_P4  = 2'd0;
    localparam logic [1:0] PC_ALU = 2'd1;
    localparam logic [1:0] PC_OLD = 2'd2;

    localparam logic [7:0] TO_LAST    = 8'(MEM_TIMEOUT - 1);
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    typedef enum logic [2:0] {
        S_INIT, S_EXEC, S_MWAIT, S_WB, S_FLUSH, S_TRAP
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] op_q;
    logic [7:0] wait_cnt, wait_d;
    logic [2:0] flush_cnt, flush_d;

    // func3 is consumed by the comparator/load-store decode elsewhere.
    logic unused_func3;
    assign unused_func3 = ^func3;

    // EXEC decodes the live instruction; later phases replay the latched one.
    logic [4:0] dec_op;
    assign dec_op = (state_q == S_EXEC) ? opcode : op_q;

    logic is_load, is_store, is_branch, is_jal, is_jalr;
    logic is_opimm, is_op, is_lui;
    assign is_load   = dec_op == OP_LOAD;
    assign is_store  = dec_op == OP_STORE;
    assign is_branch = dec_op == OP_BRANCH;
    assign is_jal    = dec_op == OP_JAL;
    assign is_jalr   = dec_op == OP_JALR;
    assign is_opimm  = dec_op == OP_OPIMM;
    assign is_op     = dec_op == OP_OP;
    assign is_lui    = dec_op == OP_LUI;

    always_comb begin
        imm_type = IMM_I;
        alu1_sel = ALU1_RS1;
        alu2_sel = ALU2_RS2;
        rd_sel   = RD_ALU;
        unique case (1'b1)
            is_opimm: alu2_sel = ALU2_IMM;
            is_load: begin
                alu2_sel = ALU2_IMM;
                rd_sel   = RD_MEM;
            end
            is_store: begin
                imm_type = IMM_S;
                alu2_sel = ALU2_IMM;
            end
            is_branch: begin
                imm_type = IMM_B;
                alu1_sel = ALU1_PC;
                alu2_sel = ALU2_IMM;
            end
            is_jal: begin
                imm_type = IMM_J;
                alu1_sel = ALU1_PC;
                alu2_sel = ALU2_IMM;
                rd_sel   = RD_PC4;
            end
            is_jalr: begin
                alu2_sel = ALU2_IMM;
                rd_sel   = RD_PC4;
            end
            is_lui: begin
                imm_type = IMM_U;
                rd_sel   = RD_IMM;
            end
            default: ;
        endcase
        if (state_q == S_WB) rd_sel = RD_MEM;
    end

    logic redirect;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_cnt;
        flush_d     = flush_cnt;
        pc_sel      = PC_OLD;
        reg_wr      = 1'b0;
        we          = 1'b0;
        mem_req     = 1'b0;
        nop         = 1'b0;
        illegal     = 1'b0;
        err_timeout = 1'b0;
        redirect    = 1'b0;
        busy        = state_q != S_EXEC;
        unique case (state_q)
            S_INIT: begin
                nop     = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!stall) begin
                    unique case (1'b1)
                        is_load, is_store: begin
                            mem_req = 1'b1;
                            we      = is_store;
                            state_d = S_MWAIT;
                            wait_d  = 8'd0;
                        end
                        is_jal, is_jalr: begin
                            reg_wr   = 1'b1;
                            pc_sel   = PC_ALU;
                            redirect = 1'b1;
                        end
                        is_branch: begin
                            pc_sel   = b ? PC_ALU : PC_P4;
                            redirect = b;
                        end
                        is_op, is_opimm, is_lui: begin
                            reg_wr = 1'b1;
                            pc_sel = PC_P4;
                        end
                        default: begin
                            illegal = 1'b1;
                            pc_sel  = PC_P4;
                            if (ILLEGAL_TRAP) state_d = S_TRAP;
                        end
                    endcase
                    if (redirect && FLUSH_CYCLES != 0) begin
                        state_d = S_FLUSH;
                        flush_d = FLUSH_INIT;
                    end
                end
            end
            S_MWAIT: begin
                mem_req = 1'b1;
                we      = is_store;
                if (mem_ack) begin
                    if (is_store) begin
                        pc_sel  = PC_P4;
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_cnt >= TO_LAST) begin
                    err_timeout = 1'b1;
                    state_d     = S_TRAP;
                end else if (wait_cnt != 8'hFF) begin
                    wait_d = wait_cnt + 8'd1;
                end
            end
            S_WB: begin
                reg_wr  = 1'b1;
                pc_sel  = PC_P4;
                state_d = S_EXEC;
            end
            S_FLUSH: begin
                nop     = 1'b1;
                pc_sel  = PC_P4;
                flush_d = flush_cnt - 3'd1;
                if (flush_cnt <= 3'd1) state_d = S_EXEC;
            end
            S_TRAP: nop = 1'b1;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_INIT;
            op_q      <= 5'd0;
            wait_cnt  <= 8'd0;
            flush_cnt <= 3'd0;
        end else begin
            state_q   <= state_d;
            wait_cnt  <= wait_d;
            flush_cnt <= flush_d;
            if (state_q == S_EXEC) op_q <= opcode;
        end
    end

endmodule

// File: tb/tb_ctrl_mc.sv
// tb_ctrl_mc: randomized self-checking bench for ctrl_mc.
// Two instances cover the flush/timeout/trap parameter corners.
module tb_ctrl_mc;

    localparam logic [4:0] LOAD = 5'b00000, STORE = 5'b01000;
    localparam logic [4:0] BRANCH = 5'b11000, JALR = 5'b11001;
    localparam logic [4:0] JAL = 5'b11011, OPIMM = 5'b00100;
    localparam logic [4:0] OPR = 5'b01100, LUI = 5'b01101;
    localparam logic [4:0] BAD1 = 5'b11111, BAD2 = 5'b11010;

    localparam logic [2:0] I_I = 3'd0, I_S = 3'd1, I_B = 3'd2;
    localparam logic [2:0] I_U = 3'd3, I_J = 3'd4;
    localparam logic [1:0] R_ALU = 2'd0, R_MEM = 2'd1;
    localparam logic [1:0] R_PC4 = 2'd2, R_IMM = 2'd3;
    localparam logic [1:0] P4 = 2'd0, PALU = 2'd1, POLD = 2'd2;

    localparam int MT_A = 4, FC_A = 2, MT_B = 1, FC_B = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] opc [2];
    logic [2:0] f3;
    logic       st [2];
    logic       ack [2];
    logic       bb [2];

    logic [2:0] a_imm, b_imm;
    logic       a_a1, a_a2, b_a1, b_a2;
    logic [1:0] a_rd, a_pc, b_rd, b_pc;
    logic       a_rw, a_we, a_mr, a_nop, a_bsy, a_ill, a_err;
    logic       b_rw, b_we, b_mr, b_nop, b_bsy, b_ill, b_err;
    logic [15:0] obs_a, obs_b;

    always #5 clk = ~clk;

    ctrl_mc #(.MEM_TIMEOUT(MT_A), .FLUSH_CYCLES(FC_A), .ILLEGAL_TRAP(1'b0)) u_a (
        .clk(clk), .rst(rst), .opcode(opc[0]), .func3(f3), .b(bb[0]),
        .stall(st[0]), .mem_ack(ack[0]), .imm_type(a_imm), .alu1_sel(a_a1),
        .alu2_sel(a_a2), .rd_sel(a_rd), .pc_sel(a_pc), .reg_wr(a_rw),
        .we(a_we), .mem_req(a_mr), .nop(a_nop), .busy(a_bsy),
        .illegal(a_ill), .err_timeout(a_err)
    );

    ctrl_mc #(.MEM_TIMEOUT(MT_B), .FLUSH_CYCLES(FC_B), .ILLEGAL_TRAP(1'b1)) u_b (
        .clk(clk), .rst(rst), .opcode(opc[1]), .func3(f3), .b(bb[1]),
        .stall(st[1]), .mem_ack(ack[1]), .imm_type(b_imm), .alu1_sel(b_a1),
        .alu2_sel(b_a2), .rd_sel(b_rd), .pc_sel(b_pc), .reg_wr(b_rw),
        .we(b_we), .mem_req(b_mr), .nop(b_nop), .busy(b_bsy),
        .illegal(b_ill), .err_timeout(b_err)
    );

    assign obs_a = {a_imm, a_a1, a_a2, a_rd, a_pc, a_rw, a_we, a_mr,
                    a_nop, a_bsy, a_ill, a_err};
    assign obs_b = {b_imm, b_a1, b_a2, b_rd, b_pc, b_rw, b_we, b_mr,
                    b_nop, b_bsy, b_ill, b_err};

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [4:0] rop();
        logic [4:0] t [10];
        t = '{OPR, OPIMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, BAD1, BAD2};
        return t[$urandom_range(0, 9)];
    endfunction

    // Datapath selects straight from the RV32I control table.
    function automatic logic [6:0] dsel(input logic [4:0] op);
        case (op)
            OPR:    return {I_I, 1'b0, 1'b0, R_ALU};
            OPIMM:  return {I_I, 1'b0, 1'b1, R_ALU};
            LOAD:   return {I_I, 1'b0, 1'b1, R_MEM};
            STORE:  return {I_S, 1'b0, 1'b1, R_ALU};
            BRANCH: return {I_B, 1'b1, 1'b1, R_ALU};
            JAL:    return {I_J, 1'b1, 1'b1, R_PC4};
            JALR:   return {I_I, 1'b0, 1'b1, R_PC4};
            LUI:    return {I_U, 1'b0, 1'b0, R_IMM};
            default: return {I_I, 1'b0, 1'b0, R_ALU};
        endcase
    endfunction

    function automatic logic [15:0] ex(
        input logic [6:0] s, input logic [1:0] pc, input logic rw,
        input logic w, input logic mr, input logic np, input logic bs,
        input logic il, input logic er);
        return {s, pc, rw, w, mr, np, bs, il, er};
    endfunction

    logic [15:0] quiet_exp;
    assign quiet_exp = ex(7'd0, POLD, 0, 0, 0, 1, 1, 0, 0);

    // One clock: drive at the falling edge, compare just after.
    task automatic cyc(input int u, input logic [4:0] o, input logic s,
                       input logic k, input logic bv, input logic [15:0] e,
                       input bit cs, input string tag);
        logic [15:0] m, g;
        @(negedge clk);
        opc[u] = o;
        st[u]  = s;
        ack[u] = k;
        bb[u]  = bv;
        f3     = 3'($urandom);
        #1;
        g = (u == 0) ? obs_a : obs_b;
        m = cs ? 16'hFFFF : 16'h01FF;
        check($sformatf("%s%0d", tag, u), g & m, e & m);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_a", obs_a & 16'h01FF, quiet_exp);
        check("rst_b", obs_b & 16'h01FF, quiet_exp);
        @(negedge clk);
        rst = 1'b1;
        opc[0] = OPIMM;
        opc[1] = OPIMM;
        #1;
        check("init_a", obs_a & 16'h01FF, quiet_exp);
        check("init_b", obs_b & 16'h01FF, quiet_exp);
    endtask

    task automatic trap_hold(input int u, input int n);
        for (int i = 0; i < n; i++)
            cyc(u, rop(), rb(), rb(), rb(), quiet_exp, 0, "trap");
    endtask

    // Expected behaviour of one instruction, cycle by cycle.
    task automatic run_instr(input int u, input logic [4:0] op,
                             input logic bv, input int nstall,
                             input int ack_at, output bit trapped);
        logic [6:0] s;
        logic [1:0] pc;
        bit ld, sw, br, jmp, wr, legal, a, last;
        int to, fcn;
        s     = dsel(op);
        ld    = op == LOAD;
        sw    = op == STORE;
        br    = op == BRANCH;
        jmp   = op == JAL || op == JALR;
        wr    = op == OPR || op == OPIMM || op == LUI;
        legal = ld || sw || br || jmp || wr;
        to    = (u == 0) ? MT_A : MT_B;
        fcn   = (u == 0) ? FC_A : FC_B;
        trapped = 0;
        for (int i = 0; i < nstall; i++)
            cyc(u, op, 1, rb(), rb(), ex(s, POLD, 0, 0, 0, 0, 0, 0, 0), 1, "stall");
        if (!legal) begin
            cyc(u, op, 0, rb(), rb(), ex(s, P4, 0, 0, 0, 0, 0, 1, 0), 1, "illegal");
            trapped = (u == 1);
        end else if (ld || sw) begin
            cyc(u, op, 0, rb(), rb(), ex(s, POLD, 0, sw, 1, 0, 0, 0, 0), 1, "memreq");
            for (int k = 1; k <= to; k++) begin
                a    = k == ack_at;
                last = (k == to) && !a;
                pc   = (a && sw) ? P4 : POLD;
                cyc(u, rop(), rb(), a, rb(), ex(s, pc, 0, sw, 1, 0, 1, 0, last), 1, "mwait");
                if (a) break;
                if (last) trapped = 1;
            end
            if (ld && !trapped)
                cyc(u, rop(), rb(), rb(), rb(), ex(s, P4, 1, 0, 0, 0, 1, 0, 0), 1, "wb");
        end else if (jmp || (br && bv)) begin
            cyc(u, op, 0, rb(), bv, ex(s, PALU, jmp, 0, 0, 0, 0, 0, 0), 1, "jump");
            for (int k = 0; k < fcn; k++)
                cyc(u, rop(), rb(), rb(), rb(), ex(s, P4, 0, 0, 0, 1, 1, 0, 0), 0, "flush");
        end else begin
            cyc(u, op, 0, rb(), bv, ex(s, P4, wr, 0, 0, 0, 0, 0, 0), 1, "exec");
        end
    endtask

    task automatic run_rand(input int u, input int n);
        bit t;
        int to;
        to = (u == 0) ? MT_A : MT_B;
        for (int i = 0; i < n; i++) begin
            run_instr(u, rop(), rb(),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      $urandom_range(0, to), t);
            if (t) begin
                trap_hold(u, 3);
                do_reset();
            end
        end
    endtask

    bit tr;

    initial begin
        for (int i = 0; i < 2; i++) begin
            opc[i] = OPIMM;
            st[i]  = 1'b0;
            ack[i] = 1'b0;
            bb[i]  = 1'b0;
        end
        f3 = 3'd0;
        #12;
        do_reset();

        run_instr(0, OPIMM, 0, 0, 0, tr);
        run_instr(0, LOAD, 0, 0, 3, tr);
        run_instr(0, STORE, 0, 0, 1, tr);
        run_instr(0, BRANCH, 1, 0, 0, tr);
        run_instr(0, BRANCH, 0, 0, 0, tr);
        run_instr(0, BAD1, 0, 0, 0, tr);
        run_instr(0, JAL, 0, 2, 0, tr);
        run_instr(0, LOAD, 0, 0, MT_A, tr);
        run_instr(0, LOAD, 0, 0, 0, tr);
        check("to_trap", 16'(tr), 16'd1);
        trap_hold(0, 4);
        do_reset();

        run_instr(0, LUI, 0, 0, 0, tr);
        cyc(0, STORE, 0, 0, 0, ex(dsel(STORE), POLD, 0, 1, 1, 0, 0, 0, 0), 1, "pre_rst");
        cyc(0, OPR, 0, 0, 0, ex(dsel(STORE), POLD, 0, 1, 1, 0, 1, 0, 0), 1, "pre_rst");
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst", obs_a & 16'h01FF, quiet_exp);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_init", obs_a & 16'h01FF, quiet_exp);
        run_instr(0, JALR, 0, 1, 0, tr);

        run_rand(0, 200);

        do_reset();
        run_instr(1, JAL, 0, 0, 0, tr);
        run_instr(1, BRANCH, 1, 1, 0, tr);
        run_instr(1, LOAD, 0, 0, 1, tr);
        run_instr(1, STORE, 0, 0, 1, tr);
        run_instr(1, OPR, 0, 0, 0, tr);
        run_instr(1, LOAD, 0, 0, 0, tr);
        trap_hold(1, 3);
        do_reset();
        run_instr(1, BAD1, 0, 0, 0, tr);
        trap_hold(1, 3);
        do_reset();

        run_rand(1, 80);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
